i2s_transmitter: RTL and testbench
==================================

// Module: i2s_transmitter
// PURPOSE
//  I2S bus master transmitter and the playback-direction counterpart of the capture path: generates i2s_clk/i2s_ws and serializes PCM onto i2s_sd.
//  Buffers samples from an internal producer (SPI bridge or DSP) in a small FIFO and drives an external DAC/amplifier.
//  Sends each sample on both channels (mono); on FIFO underrun it sends silence.
// PARAMETERS
//  DATA_WIDTH     16           PCM sample width, two's complement
//  I2S_DATA_SIZE  24           bit-clock slots per channel; must be >= DATA_WIDTH
//  CLK_FREQ       100_000_000  system clock, Hz
//  I2S_CLK_FREQ   1_500_000    target bit clock, Hz; HALF_DIV = CLK_FREQ/(2*I2S_CLK_FREQ), truncated, must be >= 2
//  FIFO_DEPTH     16           sample FIFO entries, power of 2
// PORTS
//  clk           in   1                          system clock
//  rst           in   1                          asynchronous, active-high reset
//  enable_i      in   1                          run the bus; sampled only at frame boundaries
//  pcm_in        in   DATA_WIDTH                 sample to queue
//  pcm_valid_i   in   1                          pcm_in valid
//  pcm_ready_o   out  1                          FIFO can accept; equals !full
//  fifo_level_o  out  $clog2(FIFO_DEPTH+1)       samples currently queued
//  i2s_clk       out  1                          bit clock (BCLK)
//  i2s_ws        out  1                          word select: 0 = left, 1 = right
//  i2s_sd        out  1                          serial data, MSB first
//  frame_start_o out  1                          1-cycle pulse when a frame is loaded
//  underrun_o    out  1                          1-cycle pulse when a frame loads from an empty FIFO
// BEHAVIOUR
//  Reset values: i2s_clk=0, i2s_ws=0, i2s_sd=0, frame_start_o=0, underrun_o=0, fifo_level_o=0, pcm_ready_o=1. Reset mid-frame aborts immediately and flushes the FIFO.
//  Push: a sample is written when pcm_valid_i && pcm_ready_o. pcm_ready_o=0 when level==FIFO_DEPTH, including in a cycle with a same-cycle pop.
//  Push and pop in the same cycle with 0<level<DEPTH: level is unchanged.
//  Divider: counter 0..HALF_DIV-1. On wrap, i2s_clk toggles. Output regs (i2s_sd, i2s_ws) update only on the clk cycle that drives i2s_clk 1->0 (falling edge); the receiver samples on the rising edge.
//  Frame: 2*I2S_DATA_SIZE BCLK periods, bit index 0..2*I2S_DATA_SIZE-1.
//  i2s_ws is 0 for indices 0..I2S_DATA_SIZE-1 and 1 for the rest. It changes one BCLK before the MSB of each channel (Philips 1-bit delay), so the slot MSB appears on the falling edge after the ws transition.
//  Slot word: {sample, (I2S_DATA_SIZE-DATA_WIDTH) zeros}, left-justified. The same word is used for left and right. i2s_sd = word[I2S_DATA_SIZE-1-(bit mod I2S_DATA_SIZE)], delayed one BCLK relative to ws.
//  Frame load: on the falling edge that sets ws 1->0 (and on the first edge after enable):
//    - If level>0: pop one sample.
//    - Else: word = 0 and pulse underrun_o.
//    - In both cases pulse frame_start_o in the same clk cycle.
//  FSM: IDLE -> RUN (enable_i=1 in IDLE: divider starts from 0, first falling edge loads a frame).
//    RUN -> STOP at the last bit of a frame when enable_i=0.
//    STOP -> IDLE after the final falling edge, with i2s_clk low, ws=0, sd=0.
//    Frames are never truncated by enable_i.
//  In IDLE the divider is held; i2s_clk, ws and sd are held low; pushes are still accepted.
//  Latency: from the first push into an empty FIFO in RUN, the sample's MSB is on sd at most one frame plus 1 BCLK later.
// CONFIGURATION
//  I2S_TX_UNDERRUN_CNT_EN defined: adds output underrun_count_o [15:0]. It increments on each underrun_o, saturates at 16'hFFFF and clears on rst.
//  Not defined: the port and counter are absent, and underrun_o behaviour is unchanged.
// STRUCTURE
//  Package i2s_pkg:
//    - typedef enum {IDLE, RUN, STOP} i2s_tx_state_t
//    - typedef enum logic {CH_LEFT=0, CH_RIGHT=1} i2s_ch_t
//    - localparam function calc_half_div(clk_freq, i2s_freq)
//  Sub-module i2s_tx_fifo: synchronous FIFO with async active-high reset, show-ahead read data and a level output. The top keeps the divider, FSM and shifter.
// TESTING (CLK_FREQ=8, I2S_CLK_FREQ=1 -> HALF_DIV=4, BCLK=8 clk, frame=384 clk unless noted)
//  1. Push 16'hA5C3, enable=1 -> frame_start_o pulse; left and right slots decode as 24'hA5C300 on rising edges; ws low for 24 BCLK, then high for 24.
//  2. Enable with empty FIFO -> underrun_o pulses once per frame, sd=0 throughout; with I2S_TX_UNDERRUN_CNT_EN, count=3 after 3 frames.
//  3. Push 17 samples back to back with enable=0 -> ready_o drops after the 16th push, level=16, the 17th is held until the first frame pops and level=15.
//  4. Drop enable_i at bit 10 of a frame -> the frame completes all 48 bits, then i2s_clk, ws and sd stay 0; re-enable restarts with the next queued sample.
//  5. Assert rst at bit 30 -> all outputs go to reset values in the same cycle, level=0, ready_o=1.
//  6. Push 16'h8000 and 16'h7FFF -> consecutive frames carry 24'h800000 then 24'h7FFF00, MSB first, with the 1-BCLK delay after each ws edge.

Source files
------------

// File: rtl/i2s_pkg.sv
// Shared types and helpers for the I2S playback transmitter.
// Holds the FSM/channel enums and the bit-clock half-period divider calculation.
package i2s_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    STOP
  } i2s_tx_state_t;

  typedef enum logic {
    CH_LEFT  = 1'b0,
    CH_RIGHT = 1'b1
  } i2s_ch_t;

  // System clocks per BCLK half period, truncated.
  function automatic int calc_half_div(
    input longint clk_freq,
    input longint i2s_freq
  );
    return int'(clk_freq / (2 * i2s_freq));
  endfunction

endpackage

// File: rtl/i2s_tx_fifo.sv
// Sample FIFO: synchronous, show-ahead read data, level output.
// Ports: clk, rst (async high), i_push/i_data, i_pop, o_data, o_full, o_empty, o_level.
module i2s_tx_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_push,
  input  logic [WIDTH-1:0]           i_data,
  input  logic                       i_pop,
  output logic [WIDTH-1:0]           o_data,
  output logic                       o_full,
  output logic                       o_empty,
  output logic [$clog2(DEPTH+1)-1:0] o_level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [LW-1:0]    r_level;
  logic             w_wr;
  logic             w_rd;

  assign o_full  = (r_level == LW'(DEPTH));
  assign o_empty = (r_level == '0);
  assign o_level = r_level;
  assign o_data  = r_mem[r_rd_ptr];

  // Full blocks a push even when a pop happens in the same cycle.
  assign w_wr = i_push && !o_full;
  assign w_rd = i_pop && !o_empty;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_wr) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_rd) r_rd_ptr <= r_rd_ptr + AW'(1);
      if (w_wr && !w_rd)
        r_level <= r_level + LW'(1);
      else if (!w_wr && w_rd)
        r_level <= r_level - LW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wr_ptr] <= i_data;
  end

endmodule

// File: rtl/i2s_transmitter.sv
// I2S master transmitter: BCLK/WS generation, mono Philips serializer, sample FIFO.
// Ports: clk, rst, enable_i, pcm_in/pcm_valid_i/pcm_ready_o, fifo_level_o,
//   i2s_clk/i2s_ws/i2s_sd, frame_start_o, underrun_o;
//   underrun_count_o only when I2S_TX_UNDERRUN_CNT_EN is defined.
module i2s_transmitter
  import i2s_pkg::*;
#(
  parameter int DATA_WIDTH    = 16,
  parameter int I2S_DATA_SIZE = 24,
  parameter int CLK_FREQ      = 100_000_000,
  parameter int I2S_CLK_FREQ  = 1_500_000,
  parameter int FIFO_DEPTH    = 16
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            enable_i,
  input  logic [DATA_WIDTH-1:0]           pcm_in,
  input  logic                            pcm_valid_i,
  output logic                            pcm_ready_o,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_level_o,
  output logic                            i2s_clk,
  output logic                            i2s_ws,
  output logic                            i2s_sd,
  output logic                            frame_start_o,
`ifdef I2S_TX_UNDERRUN_CNT_EN
  output logic [15:0]                     underrun_count_o,
`endif
  output logic                            underrun_o
);

  localparam int HALF_DIV   = calc_half_div(CLK_FREQ, I2S_CLK_FREQ);
  localparam int DIV_W      = $clog2(HALF_DIV);
  localparam int FRAME_BITS = 2 * I2S_DATA_SIZE;
  localparam int BIT_W      = $clog2(FRAME_BITS);
  localparam int PAD        = I2S_DATA_SIZE - DATA_WIDTH;
  localparam int MSB        = I2S_DATA_SIZE - 1;

  i2s_tx_state_t          r_state;
  logic [DIV_W-1:0]       r_div;
  logic [BIT_W-1:0]       r_bit;
  logic [MSB:0]           r_word;
  logic [MSB:0]           r_shift;
  logic                   r_clk;
  i2s_ch_t                r_ws;
  logic                   r_sd;
  logic                   r_frame_start;
  logic                   r_underrun;

  logic                   w_full;
  logic                   w_empty;
  logic                   w_pop;
  logic [DATA_WIDTH-1:0]  w_rd_data;
  logic [MSB:0]           w_ext;
  logic [MSB:0]           w_new_word;
  logic                   w_wrap;
  logic                   w_fall;
  logic                   w_load;
  logic [BIT_W-1:0]       w_next_bit;

  i2s_tx_fifo #(
    .WIDTH (DATA_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (pcm_valid_i),
    .i_data  (pcm_in),
    .i_pop   (w_pop),
    .o_data  (w_rd_data),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_level (fifo_level_o)
  );

  assign pcm_ready_o = !w_full;

  assign w_wrap = (r_div == DIV_W'(HALF_DIV - 1));
  assign w_fall = (r_state != IDLE) && w_wrap && r_clk;

  // r_bit is parked at the last index in IDLE so the first fall lands on 0.
  assign w_next_bit = (r_bit == BIT_W'(FRAME_BITS - 1)) ? '0
                    : r_bit + BIT_W'(1);

  assign w_load = (r_state == RUN) && w_fall && (w_next_bit == '0);
  assign w_pop  = w_load && !w_empty;

  // Left-justified slot word; silence on underrun.
  assign w_ext      = MSB'(0) | (I2S_DATA_SIZE)'(w_rd_data);
  assign w_new_word = w_empty ? '0 : (w_ext << PAD);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= IDLE;
      r_div         <= '0;
      r_bit         <= BIT_W'(FRAME_BITS - 1);
      r_word        <= '0;
      r_shift       <= '0;
      r_clk         <= 1'b0;
      r_ws          <= CH_LEFT;
      r_sd          <= 1'b0;
      r_frame_start <= 1'b0;
      r_underrun    <= 1'b0;
    end else begin
      r_frame_start <= 1'b0;
      r_underrun    <= 1'b0;
      unique case (r_state)
        IDLE: begin
          r_div   <= '0;
          r_bit   <= BIT_W'(FRAME_BITS - 1);
          r_shift <= '0;
          r_clk   <= 1'b0;
          r_ws    <= CH_LEFT;
          r_sd    <= 1'b0;
          if (enable_i) r_state <= RUN;
        end
        RUN, STOP: begin
          r_div <= w_wrap ? '0 : r_div + DIV_W'(1);
          if (w_wrap) r_clk <= !r_clk;
          if (w_fall) begin
            if (r_state == STOP) begin
              r_state <= IDLE;
              r_ws    <= CH_LEFT;
              r_sd    <= 1'b0;
            end else begin
              r_bit <= w_next_bit;
              r_ws  <= (w_next_bit >= BIT_W'(I2S_DATA_SIZE))
                       ? CH_RIGHT : CH_LEFT;
              // sd lags ws by one BCLK: emit the bit queued last period.
              r_sd  <= r_shift[MSB];
              if (w_next_bit == '0) begin
                r_word        <= w_new_word;
                r_shift       <= w_new_word;
                r_frame_start <= 1'b1;
                r_underrun    <= w_empty;
              end else if (w_next_bit == BIT_W'(I2S_DATA_SIZE)) begin
                r_shift <= r_word;
              end else begin
                r_shift <= r_shift << 1;
              end
              if (w_next_bit == BIT_W'(FRAME_BITS - 1) && !enable_i)
                r_state <= STOP;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign i2s_clk       = r_clk;
  assign i2s_ws        = r_ws;
  assign i2s_sd        = r_sd;
  assign frame_start_o = r_frame_start;
  assign underrun_o    = r_underrun;

`ifdef I2S_TX_UNDERRUN_CNT_EN
  logic [15:0] r_ucnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_ucnt <= '0;
    else if (w_load && w_empty && r_ucnt != 16'hFFFF)
      r_ucnt <= r_ucnt + 16'd1;
  end

  assign underrun_count_o = r_ucnt;
`endif

endmodule

// File: tb/tb_i2s_transmitter.sv
// Bench for i2s_transmitter: bus-level receiver plus sample-queue reference.
// Runs with HALF_DIV=4 (8 clk per BCLK, 384 clk per frame).
module tb_i2s_transmitter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable_i = 1'b0;
  logic [15:0] pcm_in = '0;
  logic        pcm_valid_i = 1'b0;
  logic        pcm_ready_o;
  logic [4:0]  fifo_level_o;
  logic        i2s_clk;
  logic        i2s_ws;
  logic        i2s_sd;
  logic        frame_start_o;
  logic        underrun_o;
`ifdef I2S_TX_UNDERRUN_CNT_EN
  logic [15:0] underrun_count_o;
`endif

  always #5 clk = ~clk;

  i2s_transmitter #(
    .DATA_WIDTH    (16),
    .I2S_DATA_SIZE (24),
    .CLK_FREQ      (8),
    .I2S_CLK_FREQ  (1),
    .FIFO_DEPTH    (16)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .enable_i         (enable_i),
    .pcm_in           (pcm_in),
    .pcm_valid_i      (pcm_valid_i),
    .pcm_ready_o      (pcm_ready_o),
    .fifo_level_o     (fifo_level_o),
    .i2s_clk          (i2s_clk),
    .i2s_ws           (i2s_ws),
    .i2s_sd           (i2s_sd),
    .frame_start_o    (frame_start_o),
`ifdef I2S_TX_UNDERRUN_CNT_EN
    .underrun_count_o (underrun_count_o),
`endif
    .underrun_o       (underrun_o)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference: queued samples and expected {channel, slot word} stream.
  logic [15:0] mq[$];
  logic [24:0] exp_slots[$];
  logic [15:0] mu = '0;

  // Receiver state.
  int          idle_cnt = 0;
  logic        prev_bclk = 1'b0;
  bit          rx_active = 1'b0;
  bit          rx_skip = 1'b1;
  bit          rx_last_ws = 1'b1;
  bit          rx_ch = 1'b0;
  int          rx_cnt = 0;
  logic [23:0] rx_word = '0;

  task automatic slot_done();
    logic [24:0] e;
    if (exp_slots.size() == 0) begin
      chk("slot_unexp", 1, 0);
    end else begin
      e = exp_slots.pop_front();
      chk("slot_ch", rx_ch, e[24]);
      chk("slot_word", rx_word, e[23:0]);
    end
  endtask

  always @(negedge clk) begin : mon
    int          sz;
    logic [15:0] s;
    logic [23:0] w;
    if (rst) begin
      idle_cnt  = 0;
      prev_bclk = 1'b0;
    end else begin
      sz = mq.size();
      if (frame_start_o) begin
        if (sz > 0) begin
          s = mq.pop_front();
          w = 24'(s) * 24'd256;
          chk("urun_lo", underrun_o, 0);
        end else begin
          w = '0;
          chk("urun_hi", underrun_o, 1);
          if (mu != 16'hFFFF) mu++;
        end
        exp_slots.push_back({1'b0, w});
        exp_slots.push_back({1'b1, w});
`ifdef I2S_TX_UNDERRUN_CNT_EN
        chk("ucnt", underrun_count_o, mu);
`endif
      end else begin
        chk("urun_q", underrun_o, 0);
      end
      if (pcm_valid_i && sz < 16) mq.push_back(pcm_in);
      chk("level", fifo_level_o, mq.size());
      chk("ready", pcm_ready_o, mq.size() < 16);

      if (i2s_clk != prev_bclk) idle_cnt = 0;
      else if (idle_cnt < 1000) idle_cnt++;

      if (i2s_clk && !prev_bclk) begin
        if (rx_skip) begin
          // The first rise after start precedes the first frame.
          rx_skip = 1'b0;
          chk("pre_ws", i2s_ws, 0);
          chk("pre_sd", i2s_sd, 0);
        end else begin
          if (rx_active) begin
            rx_cnt++;
            if (rx_cnt <= 24) rx_word = {rx_word[22:0], i2s_sd};
            if (rx_cnt == 24) slot_done();
          end
          if (i2s_ws != rx_last_ws) begin
            if (rx_active) chk("ws_len", rx_cnt, 24);
            rx_active  = 1'b1;
            rx_cnt     = 0;
            rx_word    = '0;
            rx_ch      = i2s_ws;
            rx_last_ws = i2s_ws;
          end
        end
      end
      prev_bclk = i2s_clk;

      if (idle_cnt == 16) begin
        chk("idle_clk", i2s_clk, 0);
        chk("idle_ws", i2s_ws, 0);
        chk("idle_sd", i2s_sd, 0);
        // The final right-slot LSB is padding that the stop edge cuts off.
        if (rx_active && rx_cnt == 23) begin
          rx_word = {rx_word[22:0], 1'b0};
          rx_cnt  = 24;
          slot_done();
        end
        rx_active  = 1'b0;
        rx_last_ws = 1'b1;
        rx_skip    = 1'b1;
      end
    end
  end

  task automatic drive_at_neg();
    @(negedge clk);
    #1;
  endtask

  task automatic push(input logic [15:0] d);
    drive_at_neg();
    pcm_valid_i = 1'b1;
    pcm_in      = d;
    drive_at_neg();
    pcm_valid_i = 1'b0;
  endtask

  task automatic wait_frame(input int lim, output int waited);
    waited = 0;
    do begin
      @(negedge clk);
      waited++;
    end while (!frame_start_o && waited < lim);
    if (!frame_start_o) chk("frame_timeout", 0, 1);
  endtask

  task automatic wait_idle(input int lim);
    int n;
    n = 0;
    while (idle_cnt < 17 && n < lim) begin
      @(negedge clk);
      n++;
    end
    if (idle_cnt < 17) chk("idle_timeout", 0, 1);
  endtask

  task automatic do_reset(input bit check);
    drive_at_neg();
    rst         = 1'b1;
    enable_i    = 1'b0;
    pcm_valid_i = 1'b0;
    #1;
    if (check) begin
      chk("rst_clk", i2s_clk, 0);
      chk("rst_ws", i2s_ws, 0);
      chk("rst_sd", i2s_sd, 0);
      chk("rst_fs", frame_start_o, 0);
      chk("rst_ur", underrun_o, 0);
      chk("rst_lvl", fifo_level_o, 0);
      chk("rst_rdy", pcm_ready_o, 1);
`ifdef I2S_TX_UNDERRUN_CNT_EN
      chk("rst_ucnt", underrun_count_o, 0);
`endif
    end
    mq.delete();
    exp_slots.delete();
    mu         = '0;
    rx_active  = 1'b0;
    rx_skip    = 1'b1;
    rx_last_ws = 1'b1;
    rx_cnt     = 0;
    drive_at_neg();
    drive_at_neg();
    rst = 1'b0;
  endtask

  initial begin
    int   w;
    logic quiet;

    // Power-on reset values.
    repeat (2) @(negedge clk);
    chk("por_clk", i2s_clk, 0);
    chk("por_ws", i2s_ws, 0);
    chk("por_sd", i2s_sd, 0);
    chk("por_lvl", fifo_level_o, 0);
    chk("por_rdy", pcm_ready_o, 1);
    drive_at_neg();
    rst = 1'b0;

    // Single sample: latency to first load and slot decode.
    repeat (20) @(negedge clk);
    push(16'hA5C3);
    enable_i = 1'b1;
    wait_frame(20, w);
    chk("first_load_lat", w, 9);
    repeat (100) @(negedge clk);
    #1 enable_i = 1'b0;
    wait_idle(600);

    // Empty FIFO: three silent underrun frames.
    do_reset(1'b0);
    repeat (20) @(negedge clk);
    #1 enable_i = 1'b1;
    repeat (3) wait_frame(400, w);
    #1 enable_i = 1'b0;
    wait_idle(600);
`ifdef I2S_TX_UNDERRUN_CNT_EN
    chk("ucnt3", underrun_count_o, 3);
`endif

    // Fill to full while idle; the 17th waits for the first pop.
    drive_at_neg();
    pcm_valid_i = 1'b1;
    for (int i = 0; i < 16; i++) begin
      pcm_in = 16'($urandom);
      drive_at_neg();
    end
    chk("full_lvl", fifo_level_o, 16);
    chk("full_rdy", pcm_ready_o, 0);
    pcm_in   = 16'h1717;
    enable_i = 1'b1;
    wait_frame(20, w);
    chk("pop_lvl", fifo_level_o, 15);
    chk("pop_rdy", pcm_ready_o, 1);
    drive_at_neg();
    pcm_valid_i = 1'b0;

    // Drop enable mid-frame: frame completes, bus goes quiet.
    wait_frame(400, w);
    repeat (80) @(negedge clk);
    #1 enable_i = 1'b0;
    wait_idle(600);
    quiet = 1'b0;
    repeat (30) begin
      @(negedge clk);
      quiet = quiet | i2s_clk | i2s_ws | i2s_sd | frame_start_o;
    end
    chk("stop_quiet", quiet, 0);
    #1 enable_i = 1'b1;
    repeat (2) wait_frame(400, w);

    // Reset at bit 30.
    repeat (240) @(negedge clk);
    do_reset(1'b1);

    // Extreme samples in consecutive frames.
    repeat (20) @(negedge clk);
    push(16'h8000);
    push(16'h7FFF);
    enable_i = 1'b1;
    repeat (2) wait_frame(400, w);

    // Random traffic: bursty, then sparse enough to underrun.
    for (int i = 0; i < 4000; i++) begin
      drive_at_neg();
      pcm_valid_i = ($urandom_range(0, 149) == 0);
      pcm_in      = 16'($urandom);
    end
    for (int i = 0; i < 3000; i++) begin
      drive_at_neg();
      pcm_valid_i = ($urandom_range(0, 699) == 0);
      pcm_in      = 16'($urandom);
    end
    drive_at_neg();
    pcm_valid_i = 1'b0;
    enable_i    = 1'b0;
    wait_idle(600);
    chk("slots_left", exp_slots.size(), 0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
